// File: rtl/module_display_scan_ctrl.sv
// Multiplexed 7-segment scan scheduler with anti-ghost blanking,
// leading-zero suppression and a tear-free shadow register.
module module_display_scan_ctrl #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 27000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [4*N_DIGITS-1:0]       data_in,
  input  logic                        data_valid,
  output logic                        data_ready,
  input  logic                        lz_suppress,
  output logic [N_DIGITS-1:0]         an_n,
  output logic [3:0]                  bcd_out,
  output logic [$clog2(N_DIGITS)-1:0] digit_sel,
  output logic                        frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int SW = $clog2(N_DIGITS);

  localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST =
    CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [SW-1:0] DIG_LAST   = SW'(N_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  // With no blanking configured every slot opens directly lit.
  localparam state_t SLOT_START = (BLANK_CYCLES == 0) ? SHOW : BLANK;

  state_t                state;
  logic [CW-1:0]         slot_cnt;
  logic [4*N_DIGITS-1:0] active;
  logic [4*N_DIGITS-1:0] shadow;
  logic                  pending;
  logic [N_DIGITS-1:0]   supp;
  logic                  zero_run;

  // Slot timing: blank phase, lit phase, advance digit at slot end.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      slot_cnt  <= '0;
      digit_sel <= '0;
    end else if (!en) begin
      state     <= IDLE;
      slot_cnt  <= '0;
      digit_sel <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          state     <= SLOT_START;
          slot_cnt  <= '0;
          digit_sel <= '0;
        end
        BLANK: begin
          slot_cnt <= slot_cnt + 1'b1;
          if (slot_cnt == BLANK_LAST)
            state <= SHOW;
        end
        SHOW: begin
          if (slot_cnt == SLOT_LAST) begin
            slot_cnt  <= '0;
            state     <= SLOT_START;
            digit_sel <= (digit_sel == DIG_LAST) ?
                         '0 : digit_sel + 1'b1;
          end else begin
            slot_cnt <= slot_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Accept into shadow; swap into the displayed word only between frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else if (pending && (frame_done || state == IDLE)) begin
      active  <= shadow;
      pending <= 1'b0;
    end else if (data_valid && data_ready) begin
      shadow  <= data_in;
      pending <= 1'b1;
    end
  end

  assign data_ready = !pending;

  assign frame_done = (state == SHOW) &&
                      (digit_sel == DIG_LAST) &&
                      (slot_cnt == SLOT_LAST);

  // A digit is dark when it and everything above it is zero.
  always_comb begin
    zero_run = 1'b1;
    supp     = '0;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run && (active[4*i +: 4] == 4'd0);
      supp[i]  = lz_suppress && zero_run;
    end
  end

  // Select nibble and anode for the current slot.
  always_comb begin
    bcd_out = '0;
    an_n    = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (digit_sel == SW'(i)) begin
        if (state != IDLE)
          bcd_out = active[4*i +: 4];
        if (state == SHOW && !supp[i])
          an_n[i] = 1'b0;
      end
    end
  end

endmodule
